// File: rtl/aibcr3aux_osc_pkg.sv
// Shared definitions for the aux ring-oscillator controller.
//   - osc_state_e : controller FSM encoding (also exported on ctrl_state)
//   - fuse / CSR trim bit positions for the chicken-bit source select
//   - chicken_sel : resolves the chicken bit from fuse and CSR trim words
package aibcr3aux_osc_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPwrup = 3'd1,
    StMeas  = 3'd2,
    StDone  = 3'd3,
    StFail  = 3'd4
  } osc_state_e;

  localparam int unsigned FuseValidBit   = 9;
  localparam int unsigned FuseChickenBit = 7;
  localparam int unsigned CsrChickenBit  = 7;

  // A valid fuse overrides the CSR setting.
  function automatic logic chicken_sel(input logic [9:0] fuse_trim, input logic [8:0] cr_trim);
    return fuse_trim[FuseValidBit] ? fuse_trim[FuseChickenBit] : cr_trim[CsrChickenBit];
  endfunction

endpackage

// File: rtl/aibcr3aux_osc_tgl_sync.sv
// Brings the oscillator-domain divider toggle into the reference clock domain.
//   clk    : reference clock
//   rst    : synchronous active-high reset
//   tgl_i  : asynchronous toggle (each transition = one divided oscillator event)
//   edge_o : one-cycle pulse per toggle transition, either direction
module aibcr3aux_osc_tgl_sync (
  input  logic clk,
  input  logic rst,
  input  logic tgl_i,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = tgl_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // s1/s2 form the metastability filter; s3 is the history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/aibcr3aux_osc_ctrl.sv
// Power-up sequencer and frequency monitor for the aux ring oscillator.
// Powers the oscillator up, waits SETTLE_CYC reference cycles, counts divided
// oscillator edges over WIN_CYC reference cycles and flags pass/fail against
// [cnt_min, cnt_max]. Also registers the fuse/CSR chicken bit.
//   clk, rst          : reference clock, synchronous active-high reset
//   osc_en            : run (1) / power down (0) the oscillator
//   meas_req          : re-measure pulse, honoured in DONE/FAIL only
//   osc_div_tgl       : asynchronous divided-oscillator toggle
//   cnt_min, cnt_max  : inclusive pass limits
//   fuse_trim, cr_trim: trim words carrying the chicken-bit sources
//   osc_pdb           : oscillator power-down-bar
//   chicken_bit       : resolved chicken bit
//   osc_rdy, osc_fail : measurement verdict
//   meas_cnt, meas_vld: last window edge count and its update strobe
//   ctrl_state        : FSM state (debug)
module aibcr3aux_osc_ctrl
  import aibcr3aux_osc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 256,
  parameter int unsigned WIN_CYC    = 1024,
  parameter int unsigned CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_en,
  input  logic             meas_req,
  input  logic             osc_div_tgl,
  input  logic [CNT_W-1:0] cnt_min,
  input  logic [CNT_W-1:0] cnt_max,
  input  logic [9:0]       fuse_trim,
  input  logic [8:0]       cr_trim,
  output logic             osc_pdb,
  output logic             chicken_bit,
  output logic             osc_rdy,
  output logic             osc_fail,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_vld,
  output logic [2:0]       ctrl_state
);

  // One down-counter serves both the settle and the window phases.
  localparam int unsigned MaxCyc = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int unsigned TmrW   = $clog2(MaxCyc);
  localparam logic [TmrW-1:0]  SettleLd = TmrW'(SETTLE_CYC - 1);
  localparam logic [TmrW-1:0]  WinLd    = TmrW'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CntSat   = '1;

  osc_state_e       state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic             meas_vld_q, meas_vld_d;
  logic             osc_pdb_q, osc_pdb_d;
  logic             osc_rdy_q, osc_rdy_d;
  logic             osc_fail_q, osc_fail_d;
  logic             chicken_q, chicken_d;

  logic             osc_edge;
  logic [CNT_W-1:0] edge_cnt_next;
  logic             cnt_pass;

  aibcr3aux_osc_tgl_sync u_tgl_sync (
    .clk    (clk),
    .rst    (rst),
    .tgl_i  (osc_div_tgl),
    .edge_o (osc_edge)
  );

  // Count including this cycle's edge, saturating at all-ones.
  always_comb begin
    edge_cnt_next = edge_cnt_q;
    if (osc_edge && (edge_cnt_q != CntSat)) begin
      edge_cnt_next = edge_cnt_q + 1'b1;
    end
    cnt_pass = (edge_cnt_next >= cnt_min) && (edge_cnt_next <= cnt_max);
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    edge_cnt_d = edge_cnt_q;
    meas_cnt_d = meas_cnt_q;
    meas_vld_d = 1'b0;
    chicken_d  = chicken_sel(fuse_trim, cr_trim);

    unique case (state_q)
      StIdle: begin
        if (osc_en) begin
          state_d = StPwrup;
          tmr_d   = SettleLd;
        end
      end
      StPwrup: begin
        if (tmr_q == '0) begin
          state_d    = StMeas;
          tmr_d      = WinLd;
          edge_cnt_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StMeas: begin
        edge_cnt_d = edge_cnt_next;
        if (tmr_q == '0) begin
          meas_cnt_d = edge_cnt_next;
          meas_vld_d = 1'b1;
          state_d    = cnt_pass ? StDone : StFail;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StDone, StFail: begin
        if (meas_req) begin
          state_d    = StMeas;
          tmr_d      = WinLd;
          edge_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Power-down wins over everything, including a window finishing this cycle.
    if ((state_q != StIdle) && !osc_en) begin
      state_d    = StIdle;
      meas_cnt_d = meas_cnt_q;
      meas_vld_d = 1'b0;
    end

    osc_pdb_d  = (state_d != StIdle);
    osc_rdy_d  = (state_d == StDone);
    osc_fail_d = (state_d == StFail);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      edge_cnt_q <= '0;
      meas_cnt_q <= '0;
      meas_vld_q <= 1'b0;
      osc_pdb_q  <= 1'b0;
      osc_rdy_q  <= 1'b0;
      osc_fail_q <= 1'b0;
      chicken_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      edge_cnt_q <= edge_cnt_d;
      meas_cnt_q <= meas_cnt_d;
      meas_vld_q <= meas_vld_d;
      osc_pdb_q  <= osc_pdb_d;
      osc_rdy_q  <= osc_rdy_d;
      osc_fail_q <= osc_fail_d;
      chicken_q  <= chicken_d;
    end
  end

  assign osc_pdb     = osc_pdb_q;
  assign chicken_bit = chicken_q;
  assign osc_rdy     = osc_rdy_q;
  assign osc_fail    = osc_fail_q;
  assign meas_cnt    = meas_cnt_q;
  assign meas_vld    = meas_vld_q;
  assign ctrl_state  = state_q;

endmodule
